// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a linear systolic chain: loads N weights, streams samples,
// and tags returning beats so only genuine results leave as valid.
module systolic_seq_ctrl #(
  parameter int N     = 4,
  parameter int W     = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             wgt_valid,
  output logic             wgt_ready,
  input  logic [W-1:0]     wgt_data,
  input  logic             smp_valid,
  output logic             smp_ready,
  input  logic [W-1:0]     smp_c,
  input  logic [W-1:0]     smp_x,
  output logic [W-1:0]     arr_c,
  output logic [W-1:0]     arr_x,
  output logic             arr_s,
  input  logic [W-1:0]     arr_x_ret,
  output logic [W-1:0]     res_data,
  output logic             res_valid,
  output logic             res_last,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam int WC_W = (N > 1) ? $clog2(N) : 1;
  localparam int DC_W = $clog2(N + 2);
  localparam logic [WC_W-1:0] W_LAST = WC_W'(N - 1);
  localparam logic [DC_W-1:0] D_LAST = DC_W'(N + 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WC_W-1:0]  wcnt;
  logic [LEN_W-1:0] scnt;
  logic [LEN_W-1:0] len;
  logic [DC_W-1:0]  dcnt;
  logic [N:0]       tag_v;
  logic [N:0]       tag_l;

  logic wgt_hs;
  logic smp_hs;
  logic last_hs;

  assign wgt_ready = (state == LOAD);
  assign smp_ready = (state == RUN);
  assign busy      = (state != IDLE);

  assign wgt_hs  = wgt_ready && wgt_valid;
  assign smp_hs  = smp_ready && smp_valid;
  assign last_hs = smp_hs && (scnt == len - LEN_W'(1));

  // Drain lasts N+1 cycles past the final beat so done lands at a fixed offset
  assign done = (state == DRAIN) && (dcnt == D_LAST) && (tag_v == '0);

  assign res_valid = tag_v[N];
  assign res_last  = tag_l[N];
  assign res_data  = tag_v[N] ? arr_x_ret : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (wgt_hs && wcnt == W_LAST)
                 state_nxt = (len == '0) ? DRAIN : RUN;
      RUN:     if (last_hs) state_nxt = DRAIN;
      DRAIN:   if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
      scnt  <= '0;
      len   <= '0;
      dcnt  <= '0;
      tag_v <= '0;
      tag_l <= '0;
      arr_s <= 1'b0;
      arr_c <= '0;
      arr_x <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) len <= cfg_len;

      if (state != LOAD)
        wcnt <= '0;
      else if (wgt_hs)
        wcnt <= (wcnt == W_LAST) ? '0 : wcnt + WC_W'(1);

      if (state != RUN)
        scnt <= '0;
      else if (smp_hs)
        scnt <= scnt + LEN_W'(1);

      if (state != DRAIN)
        dcnt <= '0;
      else if (dcnt != D_LAST)
        dcnt <= dcnt + DC_W'(1);

      tag_v <= {tag_v[N-1:0], smp_hs};
      tag_l <= {tag_l[N-1:0], last_hs};

      if (wgt_hs) begin
        arr_s <= 1'b1;
        arr_c <= '0;
        arr_x <= wgt_data;
      end else if (smp_hs) begin
        arr_s <= 1'b0;
        arr_c <= smp_c;
        arr_x <= smp_x;
      end else begin
        arr_s <= 1'b0;
        arr_c <= '0;
        arr_x <= '0;
      end
    end
  end

endmodule

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

Sequencer for a linear chain of `N` systolic internal cells. Each cell has a stored coefficient register `p` and a mode bit `s`, and the cells pass `c`, `x` and `s` forward one register per cell. This block loads `N` weights into the chain's `p` registers, streams samples through the chain and tags the beats returning from the last cell so that only genuine results leave as valid output. It sits between the weight/sample sources and the cell chain, and sequences one job at a time.

## Interface
- `N`, 4, number of cells in the driven chain (≥1).
- `W`, 32, data width of `c`/`x`.
- `LEN_W`, 16, width of the sample-count field.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  job request; accepted only in IDLE.
- `cfg_len`  in  LEN_W  number of samples in the job; captured on start.
- `wgt_valid` / `wgt_ready`  in/out  1  weight stream handshake.
- `wgt_data`  in  W  weight value.
- `smp_valid` / `smp_ready`  in/out  1  sample stream handshake.
- `smp_c`, `smp_x`  in  W  sample multiplier operand and addend.
- `arr_c`, `arr_x`  out  W  to first cell `c_in` / `x_in`; registered.
- `arr_s`  out  1  to first cell `s_in`; registered.
- `arr_x_ret`  in  W  `x_out` of the last cell.
- `res_data`  out  W  result; equals `arr_x_ret` when `res_valid`, else 0.
- `res_valid`, `res_last`  out  1  result qualifiers (no backpressure).
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at job end.

## Operation
- The cells have no enable, so the chain advances every cycle. Every cycle this block issues exactly one beat `{arr_s, arr_c, arr_x}`.
- Beat kinds:
  - Bubble: `s=0, c=0, x=0`. It leaves `p` unchanged and carries 0.
  - Load: `s=1, c=0, x=weight`. The cell sets `p←x_in` and passes `x_out=p_old`, so load beats shift the weight chain.
  - Compute: `s=0, c=smp_c, x=smp_x`. Each cell computes `x←x+c·p` mod 2^W.
- After `N` load beats, the first weight accepted resides in the last cell and the `N`th in the first cell.
- Tag pipeline: `N+1`-deep shift register of `{valid,last}`, advanced every cycle. A compute beat enters with `valid=1`; load and bubble beats enter with `valid=0`. `res_valid/res_last` are taken from the tag output. Old `p` values flushed out during LOAD therefore never appear as valid.
- FSM:
  - IDLE: ready outputs low; bubbles issued. On `start`, capture `cfg_len` and go to LOAD.
  - LOAD: `wgt_ready=1`. Each `wgt_valid&&wgt_ready` issues a load beat; otherwise a bubble. After the `N`th accepted weight, go to RUN, or to DRAIN if `cfg_len==0`.
  - RUN: `smp_ready=1`. Each handshake issues a compute beat; otherwise a bubble. The `cfg_len`th sample is tagged `last`, and the FSM then goes to DRAIN.
  - DRAIN: bubbles only. Stay until the tag pipeline holds no `valid`, then pulse `done` for one cycle and return to IDLE.
- `wgt_ready` and `smp_ready` are never high together. Each depends only on state and counters, never combinationally on `valid`.
- `start` outside IDLE is ignored, with no queuing. `start` and `cfg_len` are sampled only in the IDLE cycle where `start=1`.
- Counters: the weight counter counts 0..N-1; the sample counter is `LEN_W` wide. `cfg_len` maximum is 2^LEN_W−1; there is no wrap within a job.
- Reset at any time, including mid-job:
  - FSM returns to IDLE; counters and tags are cleared.
  - All outputs go to 0.
  - A partially loaded chain is not recovered; a new job reloads all `N` weights.

## Timing
- Reset values: `arr_s=0`, `arr_c=0`, `arr_x=0`, `res_data=0`, `res_valid=0`, `res_last=0`, `busy=0`, `done=0`, `wgt_ready=0`, `smp_ready=0`.
- `start` in IDLE at cycle t: `busy` and `wgt_ready` are high from t+1.
- A beat accepted at cycle t appears on `arr_*` at t+1 and on `res_valid` at t+1+N (`N` cell registers plus the issue register).
- Last sample accepted at t: `res_last` at t+1+N, `done` at t+2+N, IDLE and `busy=0` at t+3+N.
- `cfg_len=0`: `done` at t+2+N after the `N`th weight is accepted at t.
- Back-to-back jobs: `start` is accepted in the first IDLE cycle after `done`.

## Test plan
- N=4, weights 1,2,3,4, one sample `c=5, x=0`: a single `res_valid` with `res_data=50` and `res_last=1`, exactly 5 cycles after the sample handshake; `done` one cycle later.
- N=4, `cfg_len=3`, samples `(c,x)=(1,0),(2,7),(0,9)`, weights 1,1,1,1: results 4, 15, 9 in order; only the third has `res_last`; no valid during LOAD despite nonzero old `p`.
- `wgt_valid` and `smp_valid` toggled randomly: results are unchanged from the contiguous case; gaps in `res_valid` mirror input gaps; the ready signals are never both high.
- `cfg_len=0`: `N` weights accepted, no `res_valid` at all, `done` at t+2+N.
- `rst` asserted mid-RUN with 2 results in flight: next cycle all outputs are 0, IDLE, no stray `res_valid`; a following job with fresh weights produces correct results.
- `start` pulsed during LOAD/RUN/DRAIN: ignored, with no extra job and `cfg_len` unchanged; `start` at the first IDLE cycle after `done` is accepted.
